// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU instruction executor: opcodes, instruction
// layout, FSM state encoding and default framebuffer geometry.
package gpu_pkg;

    localparam int unsigned H_RES_DEF   = 160;
    localparam int unsigned V_RES_DEF   = 120;
    localparam int unsigned ADDR_W_DEF  = 15;
    localparam int unsigned COLOR_W_DEF = 8;
    localparam int unsigned CRD_W       = 8;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_CURSOR = 8'h01;
    localparam logic [7:0] OP_SET_COLOR  = 8'h02;
    localparam logic [7:0] OP_PUT_PIXEL  = 8'h03;
    localparam logic [7:0] OP_FILL_RUN   = 8'h04;
    localparam logic [7:0] OP_CLEAR      = 8'h05;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_WRITE  = 3'd2;
    localparam logic [2:0] ST_FILL   = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Instruction word: opcode in the low byte, arguments above it.
    typedef struct packed {
        logic [7:0] arg2;
        logic [7:0] arg1;
        logic [7:0] arg0;
        logic [7:0] opcode;
    } instr_t;

endpackage

// File: rtl/gpu_cursor.sv
// Drawing cursor: x/y with clamp on load, raster-order wrap on advance, and a
// linear framebuffer address kept in step with x/y.
module gpu_cursor
    import gpu_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEF,
    parameter int unsigned V_RES  = V_RES_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [CRD_W-1:0]  i_x,
    input  logic [CRD_W-1:0]  i_y,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [CRD_W-1:0] X_MAX = CRD_W'(H_RES - 1);
    localparam logic [CRD_W-1:0] Y_MAX = CRD_W'(V_RES - 1);

    logic [CRD_W-1:0]  r_x;
    logic [CRD_W-1:0]  r_y;
    logic [CRD_W-1:0]  w_x_cl;
    logic [CRD_W-1:0]  w_y_cl;
    logic [ADDR_W-1:0] w_load_addr;

    always_comb begin
        w_x_cl      = (i_x > X_MAX) ? X_MAX : i_x;
        w_y_cl      = (i_y > Y_MAX) ? Y_MAX : i_y;
        w_load_addr = ADDR_W'(w_y_cl) * ADDR_W'(H_RES) + ADDR_W'(w_x_cl);
    end

    // Linear address is multiplied once at load and then incremented alongside x/y.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_x    <= '0;
            r_y    <= '0;
            o_addr <= '0;
        end else if (i_load) begin
            r_x    <= w_x_cl;
            r_y    <= w_y_cl;
            o_addr <= w_load_addr;
        end else if (i_advance) begin
            if (r_x == X_MAX) begin
                r_x <= '0;
                if (r_y == Y_MAX) begin
                    r_y    <= '0;
                    o_addr <= '0;
                end else begin
                    r_y    <= r_y + CRD_W'(1);
                    o_addr <= o_addr + ADDR_W'(1);
                end
            end else begin
                r_x    <= r_x + CRD_W'(1);
                o_addr <= o_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpu_instruction_executor.sv
// Decodes assembled 32-bit instructions and drives framebuffer pixel writes
// (cursor/colour state, single pixel, horizontal run, full clear).
module gpu_instruction_executor
    import gpu_pkg::*;
#(
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned COLOR_W = COLOR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_instruction,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic               o_fb_we,
    output logic [ADDR_W-1:0]  o_fb_addr,
    output logic [COLOR_W-1:0] o_fb_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    logic [2:0]         r_state;
    logic               r_ready_q;
    instr_t             r_instr;
    logic [COLOR_W-1:0] r_color;
    logic [7:0]         r_remaining;
    logic [ADDR_W-1:0]  r_clr_addr;

    logic [2:0]         w_next_state;
    logic               w_accept;
    logic               w_issue;
    logic [ADDR_W-1:0]  w_issue_addr;
    logic               w_advance;
    logic               w_load;
    logic               w_color_we;
    logic               w_err;
    logic               w_rem_load;
    logic               w_rem_dec;
    logic               w_clr_start;
    logic               w_clr_inc;
    logic [ADDR_W-1:0]  w_cur_addr;
    logic               w_unused_arg2;

    assign w_accept      = (r_state == ST_IDLE) && i_ready && !r_ready_q && !o_busy;
    assign w_unused_arg2 = ^r_instr.arg2;

    gpu_cursor #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_load),
        .i_x       (r_instr.arg0),
        .i_y       (r_instr.arg1),
        .i_advance (w_advance),
        .o_addr    (w_cur_addr)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // A write is issued one cycle ahead of its visible o_fb_we cycle.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_issue_addr = w_cur_addr;
        w_advance    = 1'b0;
        w_load       = 1'b0;
        w_color_we   = 1'b0;
        w_err        = 1'b0;
        w_rem_load   = 1'b0;
        w_rem_dec    = 1'b0;
        w_clr_start  = 1'b0;
        w_clr_inc    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_DECODE;
            ST_DECODE: begin
                w_next_state = ST_DONE;
                case (r_instr.opcode)
                    OP_NOP: ;
                    OP_SET_CURSOR: w_load = 1'b1;
                    OP_SET_COLOR:  w_color_we = 1'b1;
                    OP_PUT_PIXEL: begin
                        w_next_state = ST_WRITE;
                        w_issue      = 1'b1;
                        w_advance    = 1'b1;
                    end
                    OP_FILL_RUN: begin
                        if (r_instr.arg0 != 8'd0) begin
                            w_next_state = ST_FILL;
                            w_issue      = 1'b1;
                            w_advance    = 1'b1;
                            w_rem_load   = 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        w_next_state = ST_CLEAR;
                        w_issue      = 1'b1;
                        w_issue_addr = '0;
                        w_clr_start  = 1'b1;
                    end
                    default: w_err = 1'b1;
                endcase
            end
            ST_WRITE: w_next_state = ST_DONE;
            ST_FILL: begin
                if (r_remaining == 8'd0) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_issue   = 1'b1;
                    w_advance = 1'b1;
                    w_rem_dec = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (r_clr_addr == LAST_ADDR) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_clr_addr + ADDR_W'(1);
                    w_clr_inc    = 1'b1;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ready_q   <= 1'b0;
            r_instr     <= '0;
            r_color     <= '0;
            r_remaining <= '0;
            r_clr_addr  <= '0;
        end else begin
            r_ready_q <= i_ready;
            if (w_accept)   r_instr <= instr_t'(i_instruction);
            if (w_color_we) r_color <= r_instr.arg0[COLOR_W-1:0];
            if (w_rem_load)     r_remaining <= r_instr.arg0 - 8'd1;
            else if (w_rem_dec) r_remaining <= r_remaining - 8'd1;
            if (w_clr_start)    r_clr_addr <= '0;
            else if (w_clr_inc) r_clr_addr <= r_clr_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_fb_we   <= 1'b0;
            o_fb_addr <= '0;
            o_fb_data <= '0;
        end else begin
            o_busy    <= (w_next_state != ST_IDLE);
            o_done    <= (w_next_state == ST_DONE);
            o_error   <= w_err;
            o_fb_we   <= w_issue;
            o_fb_addr <= w_issue ? w_issue_addr : '0;
            o_fb_data <= w_issue ? r_color : '0;
        end
    end

endmodule
